// File: rtl/cook_timer.sv
// cook_timer: BCD mm:ss countdown timer for the microwave controller.
// Keypad digits shift in from the right while the magnetron is off. While the
// magnetron runs, a prescaler produces one tick per second and each tick
// decrements the time with BCD borrow. tdone pulses for one cycle after the
// decrement that lands on 00:00.
module cook_timer #(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       limpan,
    input  logic       magnetron_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       zero,
    output logic       tdone,
    output logic [1:0] estado
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        VAZIO    = 2'd0,
        PRONTO   = 2'd1,
        CONTANDO = 2'd2,
        FIM      = 2'd3
    } estado_t;

    // One-second BCD decrement with borrow. Only used on a nonzero time, so
    // the min_tens borrow never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    logic [3:0]    r_min_tens;
    logic [3:0]    r_min_units;
    logic [3:0]    r_sec_tens;
    logic [3:0]    r_sec_units;
    logic [PW-1:0] r_presc;
    logic          r_tdone;
    estado_t       r_estado;

    logic [15:0]   w_time;
    logic [15:0]   w_shift;
    logic [15:0]   w_dec;
    logic          w_zero;
    logic          w_digit_ok;
    logic          w_shift_nz;
    logic          w_run;
    logic          w_tick;
    logic          w_dec_zero;

    assign w_time     = {r_min_tens, r_min_units, r_sec_tens, r_sec_units};
    assign w_zero     = (w_time == 16'h0000);
    assign w_digit_ok = digit_valid && !magnetron_on && (digit <= 4'd9);
    assign w_shift    = {r_min_units, r_sec_tens, r_sec_units, digit};
    assign w_shift_nz = (w_shift != 16'h0000);
    assign w_run      = magnetron_on && !w_zero;
    assign w_tick     = w_run && (r_presc == PRESC_MAX);
    assign w_dec      = bcd_dec(w_time);
    assign w_dec_zero = (w_dec == 16'h0000);

    // Time digits, prescaler, done pulse and controller state; limpan clears
    // everything and beats digit entry, which beats the countdown tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min_tens  <= 4'd0;
            r_min_units <= 4'd0;
            r_sec_tens  <= 4'd0;
            r_sec_units <= 4'd0;
            r_presc     <= '0;
            r_tdone     <= 1'b0;
            r_estado    <= VAZIO;
        end else if (!limpan) begin
            r_min_tens  <= 4'd0;
            r_min_units <= 4'd0;
            r_sec_tens  <= 4'd0;
            r_sec_units <= 4'd0;
            r_presc     <= '0;
            r_tdone     <= 1'b0;
            r_estado    <= VAZIO;
        end else begin
            // Pausing or sitting at 00:00 throws away the partial second.
            if (w_run) begin
                r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
            end else begin
                r_presc <= '0;
            end

            if (w_digit_ok) begin
                {r_min_tens, r_min_units, r_sec_tens, r_sec_units} <= w_shift;
                r_tdone <= 1'b0;
            end else if (w_tick) begin
                {r_min_tens, r_min_units, r_sec_tens, r_sec_units} <= w_dec;
                r_tdone <= w_dec_zero;
            end else begin
                r_tdone <= 1'b0;
            end

            case (r_estado)
                VAZIO: begin
                    if (w_digit_ok && w_shift_nz) begin
                        r_estado <= PRONTO;
                    end else begin
                        r_estado <= VAZIO;
                    end
                end
                PRONTO: begin
                    if (w_digit_ok) begin
                        r_estado <= w_shift_nz ? PRONTO : VAZIO;
                    end else if (magnetron_on) begin
                        r_estado <= CONTANDO;
                    end else begin
                        r_estado <= PRONTO;
                    end
                end
                CONTANDO: begin
                    if (w_tick && w_dec_zero) begin
                        r_estado <= FIM;
                    end else if (w_digit_ok) begin
                        r_estado <= w_shift_nz ? PRONTO : VAZIO;
                    end else if (!magnetron_on) begin
                        r_estado <= PRONTO;
                    end else begin
                        r_estado <= CONTANDO;
                    end
                end
                FIM: begin
                    if (w_digit_ok && w_shift_nz) begin
                        r_estado <= PRONTO;
                    end else begin
                        r_estado <= VAZIO;
                    end
                end
                default: begin
                    r_estado <= VAZIO;
                end
            endcase
        end
    end

    assign min_tens  = r_min_tens;
    assign min_units = r_min_units;
    assign sec_tens  = r_sec_tens;
    assign sec_units = r_sec_units;
    assign zero      = w_zero;
    assign tdone     = r_tdone;
    assign estado    = r_estado;

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- BCD mm:ss countdown timer for the microwave controller; it produces the `tdone` input consumed by the magnetron Set/Reset logic.
- Keypad digits shift in while the magnetron is off.
- While `magnetron_on` is high, the count decrements once per second; `tdone` pulses when 00:00 is reached.
- Sits between the keypad decoder, the magnetron latch output and the 7-segment display drivers.

Parameters:
- TICKS_PER_SEC, 100, clk cycles per decremented second (synthesis sets the board clock rate; benches use a small value); must be ≥ 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- digit_valid  in  1  one-cycle strobe, `digit` is valid
- digit  in  4  BCD keypad digit 0-9
- limpan  in  1  synchronous active-low clear of time and state
- magnetron_on  in  1  magnetron latch output; high enables countdown
- min_tens  out  4  BCD minutes tens
- min_units  out  4  BCD minutes units
- sec_tens  out  4  BCD seconds tens
- sec_units  out  4  BCD seconds units
- zero  out  1  level, high when all four digits are 0
- tdone  out  1  one-cycle pulse when a decrement lands on 00:00
- estado  out  2  FSM state: 0 VAZIO, 1 PRONTO, 2 CONTANDO, 3 FIM

Behaviour:
- Reset (async, `rst_n`=0):
  - all digits 0, prescaler 0, `tdone`=0, `zero`=1, `estado`=VAZIO.
- Priority per clock edge: `limpan`=0 > digit entry > tick decrement.
- `limpan`=0:
  - same result as reset, but synchronous; overrides any simultaneous digit or tick.
- Digit entry: accepted only when `digit_valid`=1, `magnetron_on`=0 and `digit`≤9.
  - Shift left: min_tens←min_units, min_units←sec_tens, sec_tens←sec_units, sec_units←digit.
  - The old min_tens is discarded (5th digit drops the oldest).
  - `digit`>9 is ignored. Entry while `magnetron_on`=1 is ignored.
  - sec_tens up to 9 is legal on entry (e.g. 01:99).
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while `magnetron_on`=1 and `zero`=0.
  - On reaching TICKS_PER_SEC-1 it wraps to 0 and asserts an internal tick for that cycle.
  - Forced to 0 whenever `magnetron_on`=0 or `zero`=1: a pause discards the partial second.
  - First decrement occurs TICKS_PER_SEC cycles after `magnetron_on` rises.
- Decrement on tick, BCD with borrow:
  - sec_units 0→9 borrows sec_tens.
  - sec_tens 0→5 borrows min_units.
  - min_units 0→9 borrows min_tens.
  - A nonzero digit simply decrements (sec_tens 9→8 allowed).
  - Never decrements from 00:00: no wrap to 99:59.
- `tdone`:
  - High for exactly one cycle, the cycle after the decrement that produces 00:00.
  - Never asserted by `limpan`, by reset, or by `magnetron_on` rising while already 00:00.
- `zero`: combinational from the digit registers.
- FSM:
  - VAZIO→PRONTO on an accepted nonzero digit that makes `zero`=0.
  - PRONTO→CONTANDO when `magnetron_on`=1.
  - CONTANDO→PRONTO when `magnetron_on`=0 with time nonzero (pause).
  - CONTANDO→FIM on the decrement reaching 00:00.
  - FIM→VAZIO the next cycle.
  - Any state→VAZIO on `limpan`=0.
  - VAZIO stays VAZIO if `magnetron_on`=1.
  - Accepted digits in VAZIO or PRONTO update the time; entering only zeros stays VAZIO.

Test Plan (TICKS_PER_SEC=4):
- Reset mid-count: apply `rst_n`=0 asynchronously between edges → all outputs at reset values immediately, `tdone` stays 0.
- Entry: keys 1,3,0 → 01:30, `estado`=PRONTO. Then key 7 → 13:07. Then key 2 → 30:72. Key 11 → no change.
- Countdown with borrow: load 01:00, `magnetron_on`=1.
  - After 4 cycles → 00:59, after 8 → 00:58.
  - Key 5 during countdown → ignored.
- Finish: load 00:02, run → 00:01 at cycle 4, 00:00 at cycle 8.
  - `tdone` high exactly one cycle, `estado` FIM then VAZIO.
  - Holding `magnetron_on`=1 longer → no further `tdone`, time stays 00:00.
- Pause: load 00:10, run 6 cycles (→00:09 plus 2 ticks of prescaler), drop `magnetron_on` → `estado`=PRONTO, time 00:09.
  - Resume → next decrement 4 cycles later.
- Simultaneous events:
  - `limpan`=0 on the same edge as a tick at 00:01 → 00:00 with `tdone`=0, `estado`=VAZIO.
  - `digit_valid` with `limpan`=0 → digit discarded.
